// File: rtl/uart_tx_encoder.sv
// 8N1 UART transmitter: takes bytes from the head of the transmit buffer and
// serialises them LSB-first, timing each bit with an internal baud counter.
module uart_tx_encoder #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic       CLK,
    input  logic       nrst,
    input  logic       tx_en,
    input  logic [7:0] data_in,
    input  logic       buffer_empty,
    output logic       rd,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_rd;
    logic             r_tx;
    logic             r_busy;
    logic             r_frame_done;

    logic             w_bit_end;
    logic             w_launch;

    assign w_bit_end = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign w_launch  = tx_en & ~buffer_empty;

    always_ff @(posedge CLK or negedge nrst) begin
        if (!nrst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_rd         <= 1'b0;
            r_tx         <= 1'b1;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_rd         <= 1'b0;
            r_frame_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_tx <= 1'b1;
                    if (w_launch) begin
                        r_shift <= data_in;
                        r_tx    <= 1'b0;
                        r_rd    <= 1'b1;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= START;
                    end
                end
                START: begin
                    if (w_bit_end) begin
                        r_cnt     <= '0;
                        r_tx      <= r_shift[0];
                        r_bit_idx <= '0;
                        r_state   <= DATA;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= STOP;
                        end else begin
                            // r_shift[0] is the bit on the line; its successor is bit 1
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_tx      <= r_shift[1];
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (w_bit_end) begin
                        r_cnt        <= '0;
                        r_busy       <= 1'b0;
                        r_frame_done <= 1'b1;
                        r_state      <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign rd         = r_rd;
    assign tx         = r_tx;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

endmodule
